// File: rtl/spi_slave_sync.sv
// ============================================================================
// Module  : spi_slave_sync
// Brief   : System-clocked SPI mode-0 responder with valid/ready rx and tx
//           handshakes. Optional sticky overrun/underrun flag when the macro
//           SPI_SLAVE_OVERRUN_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_sync #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = DATA_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
`ifdef SPI_SLAVE_OVERRUN_EN
  output logic              overrun,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sclk_prev_q;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]      tx_buf_q, tx_buf_d;
  logic                   tx_full_q, tx_full_d;
  logic                   ovr_q, ovr_d;

  logic sclk_s, mosi_s, ss_s, sclk_rise, sclk_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sclk_prev_q <= sclk_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    ovr_d      = ovr_q;

    // Capture and LOAD-consume are exclusive: one needs the buffer empty, the other full.
    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!ss_s) state_d = LOAD;
      end
      LOAD: begin
        if (tx_full_q) begin
          tx_shift_d = tx_buf_q;
          tx_full_d  = 1'b0;
        end else begin
          tx_shift_d = TX_IDLE;
          ovr_d      = 1'b1;
        end
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (ss_s) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
        end else if (sclk_fall && bit_cnt_q != '0 && bit_cnt_q != CNT_W'(DATA_W)) begin
          // The fall before bit 0's rise is skipped so the MSB stays on miso.
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
      DONE: begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        if (rx_valid_q && !rx_ready) ovr_d = 1'b1;
        state_d = ss_s ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso     = ((state_q == SHIFT) || (state_q == DONE)) && tx_shift_q[DATA_W-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~tx_full_q;
  assign busy     = (state_q != IDLE);
`ifdef SPI_SLAVE_OVERRUN_EN
  assign overrun  = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = ovr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
// ============================================================================
// Module  : tb_spi_slave_sync
// Brief   : Scoreboard bench for spi_slave_sync driving a mode-0 master model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_sync;

  logic       clk = 1'b0;
  logic       reset, sclk, mosi, ss, miso;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, busy;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_exp[$];
  logic [7:0] miso_exp[$];
  logic [7:0] miso_got[$];

  always #5 clk = ~clk;

  spi_slave_sync dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
`ifdef SPI_SLAVE_OVERRUN_EN
    .overrun(overrun),
`endif
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // rx monitor: compares every accepted word against the scoreboard
  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) begin
      n_checks++;
      if (rx_exp.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_data);
      end else begin
        logic [7:0] e;
        e = rx_exp.pop_front();
        if (rx_data !== e) begin
          n_fail++;
          $display("FAIL rx_word: got %0h expected %0h", rx_data, e);
        end
      end
    end
  end

  // miso monitor: compares each word the master collected
  always @(negedge clk) begin
    if (miso_got.size() > 0) begin
      logic [7:0] g;
      g = miso_got.pop_front();
      n_checks++;
      if (miso_exp.size() == 0) begin
        n_fail++;
        $display("FAIL miso_unexpected: got %0h expected none", g);
      end else begin
        logic [7:0] e;
        e = miso_exp.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL miso_word: got %0h expected %0h", g, e);
        end
      end
    end
  end

  // Mode-0 master, sclk = clk/8; captures miso on each rise
  task automatic spi_frame(input logic [7:0] w, input int nbits, input bit hold_ss);
    logic [7:0] cap;
    cap = '0;
    if (ss) begin
      ss = 1'b0;
      tick(8);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      tick(4);
      sclk = 1'b1;
      cap  = {cap[6:0], miso};
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    if (!hold_ss) begin
      ss = 1'b1;
      tick(8);
    end
    if (nbits == 8) miso_got.push_back(cap);
  endtask

  task automatic tx_load(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 300) begin
      tick(1);
      n++;
    end
    if (!tx_ready) check("tx_ready_timeout", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = '0;
    tick(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("rst_overrun", 32'(overrun), 32'd0);
`endif
    reset = 1'b0;
    tick(2);

    // Loaded response A5 while receiving 3C
    tx_load(8'hA5);
    check("t1_tx_ready_low", 32'(tx_ready), 32'd0);
    miso_exp.push_back(8'hA5);
    rx_exp.push_back(8'h3C);
    spi_frame(8'h3C, 8, 1'b0);
    check("t1_tx_ready_back", 32'(tx_ready), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'h3C);

    // No response loaded: idle word on miso
    miso_exp.push_back(8'hFF);
    rx_exp.push_back(8'h00);
    spi_frame(8'h00, 8, 1'b0);
    check("t2_rx_data", 32'(rx_data), 32'h00);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t2_overrun", 32'(overrun), 32'd1);
`endif

    // Back-to-back frames; second response buffered during the first
    tx_load(8'h5A);
    miso_exp.push_back(8'h5A);
    miso_exp.push_back(8'hC3);
    rx_exp.push_back(8'h11);
    rx_exp.push_back(8'h22);
    fork
      begin
        spi_frame(8'h11, 8, 1'b1);
        spi_frame(8'h22, 8, 1'b0);
      end
      begin
        int n;
        n = 0;
        while (!(busy && tx_ready) && n < 300) begin
          tick(1);
          n++;
        end
        check("t3_load_window", 32'(busy && tx_ready), 32'd1);
        tx_load(8'hC3);
      end
    join

    // Aborted frame after 5 bits, then a clean frame
    spi_frame(8'hFF, 5, 1'b0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_rx_valid", 32'(rx_valid), 32'd0);
    check("t4_rx_data", 32'(rx_data), 32'h22);
    miso_exp.push_back(8'hFF);
    rx_exp.push_back(8'h81);
    spi_frame(8'h81, 8, 1'b0);

    // Consumer stalled: second word overwrites the first
    rx_ready = 1'b0;
    miso_exp.push_back(8'hFF);
    miso_exp.push_back(8'hFF);
    spi_frame(8'h55, 8, 1'b0);
    rx_exp.push_back(8'hAA);
    spi_frame(8'hAA, 8, 1'b0);
    check("t5_rx_valid", 32'(rx_valid), 32'd1);
    check("t5_rx_data", 32'(rx_data), 32'hAA);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t5_overrun", 32'(overrun), 32'd1);
`endif
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("t5_rx_valid_clear", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;

    // Reset at bit 4 with a buffered response pending
    spi_frame(8'hF0, 4, 1'b1);
    tx_load(8'h3C);
    check("t6_tx_ready_low", 32'(tx_ready), 32'd0);
    reset = 1'b1;
    ss    = 1'b1;
    tick(1);
    check("t6_miso", 32'(miso), 32'd0);
    check("t6_rx_data", 32'(rx_data), 32'd0);
    check("t6_rx_valid", 32'(rx_valid), 32'd0);
    check("t6_tx_ready", 32'(tx_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t6_overrun", 32'(overrun), 32'd0);
`endif
    reset = 1'b0;
    tick(4);
    miso_exp.push_back(8'hFF);
    rx_exp.push_back(8'h7E);
    spi_frame(8'h7E, 8, 1'b0);

    tick(20);
    check("rx_queue_drained", 32'(rx_exp.size()), 32'd0);
    check("miso_queue_drained", 32'(miso_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
